// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state and select codes for the multi-zone alarm controller
// Purpose: main FSM state codes (also driven on the display port), arm
//          sub-FSM codes and the prog_sel parameter select codes.
// Ports:   none (package).
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_ARMED      = 3'd0,
    ST_OFF        = 3'd1,
    ST_TRIGGERED  = 3'd2,
    ST_ALARM      = 3'd3,
    ST_ALARM_HOLD = 3'd4
  } main_state_e;

  typedef enum logic [1:0] {
    ARM_WAIT_IGN_OFF    = 2'd0,
    ARM_WAIT_DOOR_OPEN  = 2'd1,
    ARM_WAIT_DOOR_CLOSE = 2'd2,
    ARM_DELAY           = 2'd3
  } arm_state_e;

  typedef enum logic [1:0] {
    SEL_ARM   = 2'd0,
    SEL_DRV   = 2'd1,
    SEL_PASS  = 2'd2,
    SEL_ALARM = 2'd3
  } prog_sel_e;

endpackage

// File: rtl/alarm_timer.sv
// rtl/alarm_timer.sv - 1 s prescaler plus 4-bit seconds countdown
// Purpose: free-running prescaler producing a one-cycle tick every CLK_HZ
//          cycles, and a seconds countdown that decrements on each tick
//          while running and pulses expired on its 1->0 step.
// Ports:   clock, reset (async, active-high)
//          load_i/load_val_i  start a count of load_val_i seconds
//          stop_i             stop counting, countdown holds its value
//          tick_o             1 s tick
//          expired_o          one-cycle pulse on the final tick
//          count_o            remaining seconds
module alarm_timer #(
  parameter int CLK_HZ = 100000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       stop_i,
  output logic       tick_o,
  output logic       expired_o,
  output logic [3:0] count_o
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    count_q, count_d;
  logic          run_q, run_d;

  assign tick_o    = (presc_q == PW'(CLK_HZ - 1));
  assign expired_o = run_q && tick_o && (count_q == 4'd1);
  assign count_o   = count_q;

  // The prescaler keeps running while idle so the armed LED can blink;
  // a load realigns it so expiry lands exactly T*CLK_HZ cycles later.
  always_comb begin
    presc_d = tick_o ? '0 : presc_q + PW'(1);
    count_d = count_q;
    run_d   = run_q;
    if (load_i) begin
      presc_d = '0;
      count_d = load_val_i;
      run_d   = 1'b1;
    end else if (stop_i) begin
      run_d = 1'b0;
    end else if (run_q && tick_o) begin
      count_d = count_q - 4'd1;
      if (count_q == 4'd1) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      count_q <= 4'd0;
      run_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/multi_zone_alarm_ctrl.sv
// rtl/multi_zone_alarm_ctrl.sv - anti-theft alarm controller for NUM_DOORS door zones
// Purpose: main alarm FSM, arm sequence sub-FSM, programmable time registers
//          and activation counter around a shared seconds timer.
// Ports:   clock, reset (async, active-high)
//          ignition, door[NUM_DOORS-1:0]       debounced synchronous inputs
//          prog_en, prog_sel, prog_val          time register write (OFF only)
//          status, siren_en                     LED and siren enable
//          state, countdown, trig_zone, alarm_count  display/status outputs
module multi_zone_alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int NUM_DOORS   = 4,
  parameter int CLK_HZ      = 100000000,
  parameter int T_ARM_DEF   = 6,
  parameter int T_DRV_DEF   = 8,
  parameter int T_PASS_DEF  = 15,
  parameter int T_ALARM_DEF = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ignition,
  input  logic [NUM_DOORS-1:0] door,
  input  logic                 prog_en,
  input  logic [1:0]           prog_sel,
  input  logic [3:0]           prog_val,
  output logic                 status,
  output logic                 siren_en,
  output logic [2:0]           state,
  output logic [3:0]           countdown,
  output logic [((NUM_DOORS > 1) ? $clog2(NUM_DOORS) : 1)-1:0] trig_zone,
  output logic [7:0]           alarm_count
);

  localparam int TZW = (NUM_DOORS > 1) ? $clog2(NUM_DOORS) : 1;

  main_state_e    state_q, state_d;
  arm_state_e     arm_q, arm_d;
  logic [3:0]     t_arm_q, t_arm_d;
  logic [3:0]     t_drv_q, t_drv_d;
  logic [3:0]     t_pass_q, t_pass_d;
  logic [3:0]     t_alarm_q, t_alarm_d;
  logic [TZW-1:0] trig_q, trig_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           status_q, status_d;

  logic           tmr_load, tmr_stop, tmr_tick, tmr_expired;
  logic [3:0]     tmr_val, tmr_count;
  logic           any_door;
  logic [TZW-1:0] low_door;

  alarm_timer #(.CLK_HZ(CLK_HZ)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .stop_i     (tmr_stop),
    .tick_o     (tmr_tick),
    .expired_o  (tmr_expired),
    .count_o    (tmr_count)
  );

  assign any_door = |door;

  // Scanning downwards leaves the lowest open door index as the result.
  always_comb begin
    low_door = '0;
    for (int i = NUM_DOORS - 1; i >= 0; i--) begin
      if (door[i]) begin
        low_door = TZW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    trig_d    = trig_q;
    cnt_d     = cnt_q;
    t_arm_d   = t_arm_q;
    t_drv_d   = t_drv_q;
    t_pass_d  = t_pass_q;
    t_alarm_d = t_alarm_q;
    tmr_load  = 1'b0;
    tmr_stop  = 1'b0;
    tmr_val   = 4'd0;

    case (state_q)
      ST_ARMED: begin
        if (ignition) begin
          state_d = ST_OFF;
          arm_d   = ARM_WAIT_IGN_OFF;
        end else if (any_door) begin
          state_d  = ST_TRIGGERED;
          tmr_load = 1'b1;
          tmr_val  = door[0] ? t_drv_q : t_pass_q;
          trig_d   = low_door;
        end
      end

      ST_OFF: begin
        case (arm_q)
          ARM_WAIT_IGN_OFF: begin
            if (!ignition) arm_d = ARM_WAIT_DOOR_OPEN;
          end
          ARM_WAIT_DOOR_OPEN: begin
            if (ignition)     arm_d = ARM_WAIT_IGN_OFF;
            else if (door[0]) arm_d = ARM_WAIT_DOOR_CLOSE;
          end
          ARM_WAIT_DOOR_CLOSE: begin
            if (ignition) begin
              arm_d = ARM_WAIT_IGN_OFF;
            end else if (!any_door) begin
              arm_d    = ARM_DELAY;
              tmr_load = 1'b1;
              tmr_val  = t_arm_q;
            end
          end
          ARM_DELAY: begin
            if (ignition) begin
              arm_d    = ARM_WAIT_IGN_OFF;
              tmr_stop = 1'b1;
            end else if (any_door) begin
              arm_d    = ARM_WAIT_DOOR_CLOSE;
              tmr_stop = 1'b1;
            end else if (tmr_expired) begin
              state_d = ST_ARMED;
            end
          end
        endcase

        // Loads above read the _q registers, so a same-cycle write only
        // affects the following load.
        if (prog_en) begin
          case (prog_sel)
            SEL_ARM:   t_arm_d   = (prog_val == 4'd0) ? 4'(T_ARM_DEF)   : prog_val;
            SEL_DRV:   t_drv_d   = (prog_val == 4'd0) ? 4'(T_DRV_DEF)   : prog_val;
            SEL_PASS:  t_pass_d  = (prog_val == 4'd0) ? 4'(T_PASS_DEF)  : prog_val;
            SEL_ALARM: t_alarm_d = (prog_val == 4'd0) ? 4'(T_ALARM_DEF) : prog_val;
          endcase
        end
      end

      ST_TRIGGERED: begin
        if (ignition) begin
          state_d  = ST_OFF;
          arm_d    = ARM_WAIT_IGN_OFF;
          tmr_stop = 1'b1;
        end else if (tmr_expired) begin
          state_d = ST_ALARM;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end

      ST_ALARM: begin
        if (ignition) begin
          state_d = ST_OFF;
          arm_d   = ARM_WAIT_IGN_OFF;
        end else if (!any_door) begin
          state_d  = ST_ALARM_HOLD;
          tmr_load = 1'b1;
          tmr_val  = t_alarm_q;
        end
      end

      ST_ALARM_HOLD: begin
        if (ignition) begin
          state_d = ST_OFF;
          arm_d   = ARM_WAIT_IGN_OFF;
        end else if (any_door) begin
          state_d  = ST_ALARM;
          tmr_stop = 1'b1;
        end else if (tmr_expired) begin
          state_d = ST_ARMED;
        end
      end

      default: state_d = ST_ARMED;
    endcase

    // LED restarts dark on every entry to ARMED, then flips each second.
    status_d = 1'b0;
    if (state_d == ST_TRIGGERED) begin
      status_d = 1'b1;
    end else if (state_d == ST_ARMED && state_q == ST_ARMED) begin
      status_d = status_q ^ tmr_tick;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ARMED;
      arm_q     <= ARM_WAIT_IGN_OFF;
      t_arm_q   <= 4'(T_ARM_DEF);
      t_drv_q   <= 4'(T_DRV_DEF);
      t_pass_q  <= 4'(T_PASS_DEF);
      t_alarm_q <= 4'(T_ALARM_DEF);
      trig_q    <= '0;
      cnt_q     <= 8'd0;
      status_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      t_arm_q   <= t_arm_d;
      t_drv_q   <= t_drv_d;
      t_pass_q  <= t_pass_d;
      t_alarm_q <= t_alarm_d;
      trig_q    <= trig_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
    end
  end

  assign state       = state_q;
  assign status      = status_q;
  assign siren_en    = (state_q == ST_ALARM) || (state_q == ST_ALARM_HOLD);
  assign countdown   = tmr_count;
  assign trig_zone   = trig_q;
  assign alarm_count = cnt_q;

endmodule

// File: tb/tb_multi_zone_alarm_ctrl.sv
// tb/tb_multi_zone_alarm_ctrl.sv - self-checking bench for multi_zone_alarm_ctrl
module tb_multi_zone_alarm_ctrl;

  localparam int HZ = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ignition = 1'b0;
  logic [3:0] door = 4'd0;
  logic       prog_en = 1'b0;
  logic [1:0] prog_sel = 2'd0;
  logic [3:0] prog_val = 4'd0;
  logic       status, siren_en;
  logic [2:0] state;
  logic [3:0] countdown;
  logic [1:0] trig_zone;
  logic [7:0] alarm_count;

  int n_total = 0;
  int n_pass  = 0;

  multi_zone_alarm_ctrl #(.NUM_DOORS(4), .CLK_HZ(HZ)) dut (
    .clock       (clock),
    .reset       (reset),
    .ignition    (ignition),
    .door        (door),
    .prog_en     (prog_en),
    .prog_sel    (prog_sel),
    .prog_val    (prog_val),
    .status      (status),
    .siren_en    (siren_en),
    .state       (state),
    .countdown   (countdown),
    .trig_zone   (trig_zone),
    .alarm_count (alarm_count)
  );

  always #5 clock = ~clock;

  // Reference model. States: 0 ARMED, 1 OFF, 2 TRIGGERED, 3 ALARM, 4 HOLD;
  // arm sub-state: 0 wait ign off, 1 wait door open, 2 wait door close, 3 delay.
  // The active count is tracked as cycles remaining until expiry.
  int m_state = 0, m_arm = 0, m_rem = 0, m_frz = 0, m_ph = 0, m_tz = 0, m_cnt = 0;
  int m_tarm = 6, m_tdrv = 8, m_tpass = 15, m_talarm = 10;
  bit m_run = 0, m_status = 0;

  function automatic void model_reset();
    m_state = 0; m_arm = 0; m_rem = 0; m_frz = 0; m_ph = 0; m_tz = 0; m_cnt = 0;
    m_tarm = 6; m_tdrv = 8; m_tpass = 15; m_talarm = 10;
    m_run = 0; m_status = 0;
  endfunction

  function automatic int prog_value(int v, int def);
    return (v == 0) ? def : v;
  endfunction

  function automatic void model_step();
    bit tick, exp, ld, st, anyd;
    int lv, ns, na;
    tick = (m_ph == HZ - 1);
    exp  = m_run && (m_rem == 0);
    anyd = (door != 4'd0);
    ld = 0; st = 0; lv = 0; ns = m_state; na = m_arm;
    if (m_state == 0) begin
      if (ignition) begin ns = 1; na = 0; end
      else if (anyd) begin
        ns = 2; ld = 1; lv = door[0] ? m_tdrv : m_tpass;
        for (int i = 3; i >= 0; i--) if (door[i]) m_tz = i;
      end
    end else if (m_state == 1) begin
      if (m_arm == 0) begin
        if (!ignition) na = 1;
      end else if (m_arm == 1) begin
        if (ignition) na = 0; else if (door[0]) na = 2;
      end else if (m_arm == 2) begin
        if (ignition) na = 0; else if (!anyd) begin na = 3; ld = 1; lv = m_tarm; end
      end else begin
        if (ignition) begin na = 0; st = 1; end
        else if (anyd) begin na = 2; st = 1; end
        else if (exp) ns = 0;
      end
      if (prog_en) begin
        if (prog_sel == 2'd0) m_tarm   = prog_value(prog_val, 6);
        if (prog_sel == 2'd1) m_tdrv   = prog_value(prog_val, 8);
        if (prog_sel == 2'd2) m_tpass  = prog_value(prog_val, 15);
        if (prog_sel == 2'd3) m_talarm = prog_value(prog_val, 10);
      end
    end else if (m_state == 2) begin
      if (ignition) begin ns = 1; na = 0; st = 1; end
      else if (exp) begin ns = 3; if (m_cnt < 255) m_cnt++; end
    end else if (m_state == 3) begin
      if (ignition) begin ns = 1; na = 0; end
      else if (!anyd) begin ns = 4; ld = 1; lv = m_talarm; end
    end else begin
      if (ignition) begin ns = 1; na = 0; end
      else if (anyd) begin ns = 3; st = 1; end
      else if (exp) ns = 0;
    end

    if (ld) begin
      m_run = 1; m_rem = lv * HZ - 1; m_ph = 0;
    end else begin
      m_ph = tick ? 0 : m_ph + 1;
      if (st) begin
        if (m_run) m_frz = m_rem / HZ + 1;
        m_run = 0;
      end else if (exp) begin
        m_run = 0; m_frz = 0;
      end else if (m_run) begin
        m_rem--;
      end
    end

    if (ns == 2) m_status = 1;
    else if (ns == 0 && m_state == 0) m_status = m_status ^ tick;
    else m_status = 0;
    m_state = ns;
    m_arm   = na;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  int e_cd;
  bit e_siren;
  always @(negedge clock) begin
    e_cd    = m_run ? (m_rem / HZ + 1) : m_frz;
    e_siren = (m_state == 3) || (m_state == 4);
    n_total++;
    if (int'(state) == m_state && status == m_status && siren_en == e_siren &&
        int'(countdown) == e_cd && int'(trig_zone) == m_tz && int'(alarm_count) == m_cnt)
      n_pass++;
    else
      $display("FAIL model_cycle t=%0t state %0d/%0d status %0b/%0b siren %0b/%0b countdown %0d/%0d trig_zone %0d/%0d alarm_count %0d/%0d (dut/required)",
               $time, state, m_state, status, m_status, siren_en, e_siren,
               countdown, e_cd, trig_zone, m_tz, alarm_count, m_cnt);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic wait_state(input int tgt, input int lim, input string name, output int n);
    n = 0;
    while (int'(state) != tgt && n < lim) begin
      @(posedge clock);
      #2;
      n++;
    end
    if (int'(state) != tgt) begin
      n_total++;
      $display("FAIL %s: timeout, state %0d required %0d", name, state, tgt);
    end
  endtask

  task automatic prog(input int sel, input int val);
    prog_sel = 2'(sel);
    prog_val = 4'(val);
    prog_en  = 1'b1;
    step(1);
    prog_en  = 1'b0;
  endtask

  task automatic arm_from_off();
    int n;
    ignition = 1'b0; door = 4'b0001;
    step(2);
    door = 4'b0000;
    step(1);
    wait_state(0, 200, "arm_seq", n);
  endtask

  initial begin
    int n;
    step(3);
    reset = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_countdown", countdown, 0);
    chk("rst_status", status, 0);
    chk("rst_siren", siren_en, 0);
    chk("rst_trig_zone", trig_zone, 0);
    chk("rst_alarm_count", alarm_count, 0);

    // Passenger door trigger.
    door = 4'b0100;
    step(1);
    chk("pass_state", state, 2);
    chk("pass_trig_zone", trig_zone, 2);
    chk("pass_countdown", countdown, 15);
    chk("pass_status", status, 1);
    wait_state(3, 400, "pass_to_alarm", n);
    chk("pass_alarm_cycles", n, 150);
    chk("pass_alarm_count", alarm_count, 1);
    chk("pass_siren", siren_en, 1);

    // Hold, reopen, close, re-arm.
    door = 4'b0000;
    step(1);
    chk("hold_state", state, 4);
    chk("hold_countdown", countdown, 10);
    step(49);
    door = 4'b1000;
    step(1);
    chk("reopen_state", state, 3);
    chk("reopen_frozen", countdown, 6);
    door = 4'b0000;
    step(1);
    chk("hold2_state", state, 4);
    wait_state(0, 300, "hold_to_armed", n);
    chk("hold_rearm_cycles", n, 100);
    chk("rearm_siren", siren_en, 0);
    chk("rearm_count", alarm_count, 1);

    // Driver door then ignition.
    door = 4'b0001;
    step(1);
    chk("drv_state", state, 2);
    chk("drv_countdown", countdown, 8);
    chk("drv_trig_zone", trig_zone, 0);
    step(39);
    ignition = 1'b1;
    step(1);
    chk("ign_state", state, 1);
    chk("ign_siren", siren_en, 0);
    chk("ign_status", status, 0);
    step(20);
    chk("ign_frozen", countdown, 5);

    // Program driver delay, then arm with an interrupted arm delay.
    prog(1, 3);
    ignition = 1'b0;
    step(2);
    door = 4'b0000;
    step(1);
    chk("armdly_countdown", countdown, 6);
    step(29);
    door = 4'b0010;
    step(1);
    chk("armdly_frozen", countdown, 4);
    chk("armdly_state", state, 1);
    door = 4'b0000;
    step(1);
    chk("armdly_reload", countdown, 6);
    wait_state(0, 200, "armdly_to_armed", n);
    chk("armdly_cycles", n, 60);
    chk("armed_entry_status", status, 0);
    step(9);
    chk("armed_status_before_tick", status, 0);
    step(1);
    chk("armed_status_after_tick", status, 1);

    // Write in ARMED is ignored; programmed driver delay used.
    prog(1, 5);
    door = 4'b0001;
    step(1);
    chk("prog_drv_countdown", countdown, 3);
    wait_state(3, 100, "prog_drv_alarm", n);
    chk("prog_drv_cycles", n, 30);
    chk("prog_alarm_count", alarm_count, 2);

    // Restore default; write coincident with arm load uses old value.
    ignition = 1'b1;
    step(1);
    prog(1, 0);
    ignition = 1'b0;
    step(2);
    door = 4'b0000;
    prog_sel = 2'd0; prog_val = 4'd2; prog_en = 1'b1;
    step(1);
    prog_en = 1'b0;
    chk("same_cycle_old_value", countdown, 6);
    wait_state(0, 200, "arm2", n);
    chk("arm2_cycles", n, 60);
    door = 4'b0001;
    step(1);
    chk("drv_default_restored", countdown, 8);

    // Short times for the saturation run.
    ignition = 1'b1;
    step(1);
    prog(1, 1);
    prog(2, 1);
    prog(3, 1);
    ignition = 1'b0;
    step(2);
    door = 4'b0000;
    step(1);
    chk("arm_new_value", countdown, 2);
    wait_state(0, 100, "arm3", n);
    chk("arm3_cycles", n, 20);

    for (int a = 2; a < 256; a++) begin
      door = 4'b0001;
      step(1);
      wait_state(3, 50, "sat_alarm", n);
      door = 4'b0000;
      step(1);
      wait_state(0, 50, "sat_armed", n);
      if (a == 253) chk("count_254", alarm_count, 254);
      if (a == 254) chk("count_255", alarm_count, 255);
    end
    chk("count_saturated", alarm_count, 255);

    // Reset in the middle of TRIGGERED.
    door = 4'b0100;
    step(1);
    chk("pre_reset_state", state, 2);
    step(3);
    reset = 1'b1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_countdown", countdown, 0);
    chk("midrst_status", status, 0);
    chk("midrst_siren", siren_en, 0);
    chk("midrst_trig_zone", trig_zone, 0);
    chk("midrst_count", alarm_count, 0);
    door = 4'b0000;
    step(2);
    reset = 1'b0;
    step(2);
    door = 4'b0001;
    step(1);
    chk("post_reset_drv_default", countdown, 8);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
